// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin block fill/writeback controller sharing one memory port between two caches
// Ports:
//   clk, rst (sync, active-low)
//   req_x/we_x/addr_x/wdata_x : requester x transaction request, direction, block address, write word
//   gnt_x/done_x/widx         : ownership, completion pulse, word index requested from the writer
//   rvalid_x/rdata/ridx       : fill word return, shared data and index
//   mem_ren/mem_wen/mem_addr/mem_din/mem_dout : main-memory port
module mem_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int BLOCK_SIZE  = 128,
  parameter int OFFSET_BITS = 7,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_0,
  input  logic                  req_1,
  input  logic                  we_0,
  input  logic                  we_1,
  input  logic [ADDR_WIDTH-1:0] addr_0,
  input  logic [ADDR_WIDTH-1:0] addr_1,
  input  logic [DATA_WIDTH-1:0] wdata_0,
  input  logic [DATA_WIDTH-1:0] wdata_1,
  output logic                  gnt_0,
  output logic                  gnt_1,
  output logic [4:0]            widx,
  output logic                  rvalid_0,
  output logic                  rvalid_1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [4:0]            ridx,
  output logic                  done_0,
  output logic                  done_1,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  mem_ren,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din
);
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  localparam logic [5:0] LAST = 6'(BLOCK_SIZE / 4);
  state_t state, next;
  logic last_gnt, win_0, win_1, sel_we, rv, wen_q;
  logic [ADDR_WIDTH-1:0] base, waddr, sel_addr;
  logic [DATA_WIDTH-1:0] din_q, sel_wdata;
  logic [5:0] issue, ret, wcnt;
  logic [MEM_LATENCY-1:0] pipe;
  // last_gnt doubles as the current owner once a grant is made
  assign win_0 = req_0 && (!req_1 || last_gnt);
  assign win_1 = req_1 && !win_0;
  assign sel_we = win_0 ? we_0 : we_1;
  assign sel_addr = win_0 ? addr_0 : addr_1;
  assign sel_wdata = last_gnt ? wdata_1 : wdata_0;
  always_comb begin
    next = state;
    next = state == IDLE ? ((win_0 || win_1) ? (sel_we ? WR : RD) : IDLE) :
           state == RD   ? ((rv && ret == LAST) ? DONE : RD) :
           state == WR   ? ((wen_q && wcnt == LAST) ? DONE : WR) : IDLE;
  end
  assign gnt_0    = (state == RD || state == WR) && !last_gnt;
  assign gnt_1    = (state == RD || state == WR) && last_gnt;
  assign done_0   = state == DONE && !last_gnt;
  assign done_1   = state == DONE && last_gnt;
  assign rvalid_0 = rv && !last_gnt;
  assign rvalid_1 = rv && last_gnt;
  assign widx     = state == WR ? wcnt[4:0] : 5'd0;
  assign mem_ren  = state == RD && issue < LAST;
  assign mem_wen  = wen_q;
  assign mem_din  = wen_q ? din_q : '0;
  assign mem_addr = mem_ren ? base + ADDR_WIDTH'({issue[4:0], 2'b00}) : wen_q ? waddr : '0;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      base     <= '0;
      issue    <= '0;
      ret      <= '0;
      wcnt     <= '0;
      pipe     <= '0;
      rv       <= 1'b0;
      rdata    <= '0;
      ridx     <= '0;
      wen_q    <= 1'b0;
      waddr    <= '0;
      din_q    <= '0;
    end else begin
      state <= next;
      // valid pipe mirrors memory latency; returns arrive in issue order so ret is the index
      pipe  <= (pipe << 1) | MEM_LATENCY'(mem_ren);
      rv    <= pipe[MEM_LATENCY-1];
      if (pipe[MEM_LATENCY-1]) begin
        rdata <= mem_dout;
        ridx  <= ret[4:0];
        ret   <= ret + 6'd1;
      end
      if (mem_ren) issue <= issue + 6'd1;
      // write word is captured one cycle after widx presents its index
      wen_q <= state == WR && wcnt < LAST;
      if (state == WR && wcnt < LAST) begin
        waddr <= base + ADDR_WIDTH'({wcnt[4:0], 2'b00});
        din_q <= sel_wdata;
        wcnt  <= wcnt + 6'd1;
      end
      if (state == IDLE && (win_0 || win_1)) begin
        last_gnt <= win_1;
        base     <= {sel_addr[ADDR_WIDTH-1:OFFSET_BITS], OFFSET_BITS'(0)};
        issue    <= '0;
        ret      <= '0;
        wcnt     <= '0;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter at memory latency 1 and 4
module tb_mem_arbiter;
  logic clk = 1'b0, rst = 1'b0;
  logic req_0 = 1'b0, req_1 = 1'b0, we_0 = 1'b0, we_1 = 1'b0;
  logic [31:0] addr_0 = '0, addr_1 = '0, wdata_0, wdata_1;
  logic gnt_0, gnt_1, rvalid_0, rvalid_1, done_0, done_1, mem_ren, mem_wen;
  logic [4:0] widx, ridx;
  logic [31:0] rdata, mem_dout, mem_addr, mem_din;
  logic q_req = 1'b0;
  logic q_gnt_0, q_gnt_1, q_rvalid_0, q_rvalid_1, q_done_0, q_done_1, q_mem_ren, q_mem_wen;
  logic [4:0] q_widx, q_ridx;
  logic [31:0] q_rdata, q_mem_dout, q_mem_addr, q_mem_din;
  logic [31:0] p1, p4 [4];
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  assign wdata_0 = 32'h6600_0000 | 32'(widx);
  assign wdata_1 = 32'h5500_0000 | 32'(widx);
  always @(posedge clk) begin
    p1 <= 32'hA000_0000 + mem_addr;
    p4[0] <= 32'hA000_0000 + q_mem_addr;
    for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
  end
  assign mem_dout = p1;
  assign q_mem_dout = p4[3];
  mem_arbiter dut (
    .clk(clk), .rst(rst), .req_0(req_0), .req_1(req_1), .we_0(we_0), .we_1(we_1),
    .addr_0(addr_0), .addr_1(addr_1), .wdata_0(wdata_0), .wdata_1(wdata_1),
    .gnt_0(gnt_0), .gnt_1(gnt_1), .widx(widx), .rvalid_0(rvalid_0), .rvalid_1(rvalid_1),
    .rdata(rdata), .ridx(ridx), .done_0(done_0), .done_1(done_1), .mem_dout(mem_dout),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din)
  );
  mem_arbiter #(.MEM_LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .req_0(q_req), .req_1(1'b0), .we_0(1'b0), .we_1(1'b0),
    .addr_0(32'h0000_1234), .addr_1(32'h0), .wdata_0(32'h0), .wdata_1(32'h0),
    .gnt_0(q_gnt_0), .gnt_1(q_gnt_1), .widx(q_widx), .rvalid_0(q_rvalid_0), .rvalid_1(q_rvalid_1),
    .rdata(q_rdata), .ridx(q_ridx), .done_0(q_done_0), .done_1(q_done_1), .mem_dout(q_mem_dout),
    .mem_ren(q_mem_ren), .mem_wen(q_mem_wen), .mem_addr(q_mem_addr), .mem_din(q_mem_din)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // grant edge is the first tick; cycle c is the c-th cycle after it
  task automatic run_fill(input bit who, input logic [31:0] base, input int other_at);
    bit ren_e, rv_e;
    for (int c = 1; c <= 36; c++) begin
      tick();
      ren_e = c <= 32;
      rv_e = c >= 3 && c <= 34;
      chk($sformatf("fill%0d_c%0d_gnt", who, c), who ? gnt_1 : gnt_0, c <= 34);
      chk($sformatf("fill%0d_c%0d_gnt_other", who, c), who ? gnt_0 : gnt_1, 0);
      chk($sformatf("fill%0d_c%0d_ren", who, c), mem_ren, ren_e);
      chk($sformatf("fill%0d_c%0d_addr", who, c), mem_addr, ren_e ? base + 32'(4 * (c - 1)) : 32'h0);
      chk($sformatf("fill%0d_c%0d_wen", who, c), mem_wen, 0);
      chk($sformatf("fill%0d_c%0d_rvalid", who, c), who ? rvalid_1 : rvalid_0, rv_e);
      chk($sformatf("fill%0d_c%0d_rvalid_other", who, c), who ? rvalid_0 : rvalid_1, 0);
      if (rv_e) begin
        chk($sformatf("fill%0d_c%0d_rdata", who, c), rdata, 32'hA000_0000 + base + 32'(4 * (c - 3)));
        chk($sformatf("fill%0d_c%0d_ridx", who, c), 32'(ridx), 32'(c - 3));
      end
      chk($sformatf("fill%0d_c%0d_done", who, c), who ? done_1 : done_0, c == 35);
      chk($sformatf("fill%0d_c%0d_done_other", who, c), who ? done_0 : done_1, 0);
      if (c == 2) begin
        if (who) addr_1 = 32'hDEAD_BEEF; else addr_0 = 32'hDEAD_BEEF;
      end
      if (c == 35) begin
        if (who) req_1 = 1'b0; else req_0 = 1'b0;
      end
      if (c == other_at) begin
        if (who) req_0 = 1'b1; else req_1 = 1'b1;
      end
    end
  endtask
  task automatic run_wr(input bit who, input logic [31:0] base);
    bit wen_e;
    for (int c = 1; c <= 35; c++) begin
      tick();
      wen_e = c >= 2 && c <= 33;
      chk($sformatf("wr%0d_c%0d_gnt", who, c), who ? gnt_1 : gnt_0, c <= 33);
      chk($sformatf("wr%0d_c%0d_gnt_other", who, c), who ? gnt_0 : gnt_1, 0);
      chk($sformatf("wr%0d_c%0d_widx", who, c), 32'(widx), c <= 32 ? 32'(c - 1) : 32'h0);
      chk($sformatf("wr%0d_c%0d_wen", who, c), mem_wen, wen_e);
      chk($sformatf("wr%0d_c%0d_addr", who, c), mem_addr, wen_e ? base + 32'(4 * (c - 2)) : 32'h0);
      chk($sformatf("wr%0d_c%0d_din", who, c), mem_din,
          wen_e ? (who ? 32'h5500_0000 : 32'h6600_0000) + 32'(c - 2) : 32'h0);
      chk($sformatf("wr%0d_c%0d_ren", who, c), mem_ren, 0);
      chk($sformatf("wr%0d_c%0d_rvalid", who, c), {rvalid_0, rvalid_1}, 0);
      chk($sformatf("wr%0d_c%0d_done", who, c), who ? done_1 : done_0, c == 34);
      if (c == 3) begin
        if (who) begin addr_1 = 32'hDEAD_BEEF; we_1 = 1'b0; end
        else begin addr_0 = 32'hDEAD_BEEF; we_0 = 1'b0; end
      end
      if (c == 34) begin
        if (who) req_1 = 1'b0; else req_0 = 1'b0;
      end
    end
  endtask
  initial begin
    repeat (3) tick();
    chk("rst_gnt", {gnt_0, gnt_1}, 0);
    chk("rst_mem", {mem_ren, mem_wen}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_din", mem_din, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_idx", {ridx, widx}, 0);
    chk("rst_flags", {rvalid_0, rvalid_1, done_0, done_1}, 0);
    rst = 1'b1;
    addr_0 = 32'h0000_1234; we_0 = 1'b0; req_0 = 1'b1;
    run_fill(0, 32'h0000_1200, 0);
    addr_1 = 32'h0000_0480; we_1 = 1'b1; req_1 = 1'b1;
    run_wr(1, 32'h0000_0480);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    addr_0 = 32'h0000_2000; addr_1 = 32'h0000_3000; we_1 = 1'b1;
    req_0 = 1'b1; req_1 = 1'b1;
    run_fill(0, 32'h0000_2000, 0);
    req_0 = 1'b1; addr_0 = 32'h0000_2000;
    run_wr(1, 32'h0000_3000);
    req_1 = 1'b1; addr_1 = 32'h0000_3000; we_1 = 1'b1; addr_0 = 32'h0000_2000;
    run_fill(0, 32'h0000_2000, 0);
    run_wr(1, 32'h0000_3000);
    addr_0 = 32'h0000_1234; addr_1 = 32'h0000_0480; we_1 = 1'b1; req_0 = 1'b1;
    run_fill(0, 32'h0000_1200, 10);
    run_wr(1, 32'h0000_0480);
    addr_0 = 32'h0000_1234; req_0 = 1'b1;
    repeat (11) tick();
    chk("midrst_word10_addr", mem_addr, 32'h0000_1228);
    rst = 1'b0; req_0 = 1'b0;
    tick();
    chk("midrst_gnt", {gnt_0, gnt_1}, 0);
    chk("midrst_mem", {mem_ren, mem_wen}, 0);
    chk("midrst_addr", mem_addr, 0);
    chk("midrst_rdata", rdata, 0);
    chk("midrst_flags", {rvalid_0, rvalid_1, done_0, done_1, ridx}, 0);
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk($sformatf("postrst_c%0d_quiet", c), {rvalid_0, rvalid_1, mem_ren, gnt_0}, 0);
    end
    addr_0 = 32'h0000_1234; req_0 = 1'b1;
    run_fill(0, 32'h0000_1200, 0);
    q_req = 1'b1;
    for (int c = 1; c <= 39; c++) begin
      tick();
      chk($sformatf("lat4_c%0d_ren", c), q_mem_ren, c <= 32);
      chk($sformatf("lat4_c%0d_rvalid", c), q_rvalid_0, c >= 6 && c <= 37);
      if (c >= 6 && c <= 37) begin
        chk($sformatf("lat4_c%0d_rdata", c), q_rdata, 32'hA000_1200 + 32'(4 * (c - 6)));
        chk($sformatf("lat4_c%0d_ridx", c), 32'(q_ridx), 32'(c - 6));
      end
      chk($sformatf("lat4_c%0d_done", c), q_done_0, c == 38);
      chk($sformatf("lat4_c%0d_gnt", c), q_gnt_0, c <= 37);
      if (c == 38) q_req = 1'b0;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
